// File: rtl/halton_pkg.sv
// Shared state type and constant helpers for the Halton radical-inverse generator.
package halton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Bits needed to represent the values 0..v-1 (never less than 1).
  function automatic int unsigned clog2_f(input longint unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 64'd1;
    for (int i = 0; i < 63; i++) begin
      if (p < v) begin
        p = p << 1;
        r = r + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic longint unsigned pow_f(input int unsigned b, input int unsigned e);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < e; i++) p = p * 64'(b);
    return p;
  endfunction

  // Delta added to out when k trailing digits are BASE-1 (k < d); two's complement, mod 2^64.
  function automatic longint unsigned carry_adj_f(input int unsigned b, input int unsigned d,
                                                  input int unsigned k);
    longint unsigned sub;
    sub = 64'd0;
    for (int unsigned j = 0; j < k; j++) sub = sub + 64'(b - 1) * pow_f(b, d - 1 - j);
    return pow_f(b, d - 1 - k) - sub;
  endfunction

endpackage

// File: rtl/halton_digit_cnt.sv
// BASE-modulus digit counter: loads sanitised seed digits, increments with a mixed
// carry chain, and reports the number k of trailing digits equal to BASE-1.
module halton_digit_cnt
  import halton_pkg::*;
#(
  parameter int unsigned BASE   = 3,
  parameter int unsigned DIGITS = 12,
  parameter int unsigned DW     = 2,
  parameter int unsigned KW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 inc_i,
  input  logic [DIGITS*DW-1:0] seed_dig_i,
  output logic [DIGITS*DW-1:0] dig_o,
  output logic [KW-1:0]        k_o,
  output logic                 seed_bad_o
);

  logic [DIGITS*DW-1:0] dig_q, dig_d, seed_clean, dig_inc;
  logic                 stop;

  always_comb begin
    seed_clean = seed_dig_i;
    seed_bad_o = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (32'(seed_dig_i[i*DW +: DW]) >= BASE) begin
        seed_clean[i*DW +: DW] = '0;
        seed_bad_o             = 1'b1;
      end
    end
  end

  always_comb begin
    k_o  = '0;
    stop = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!stop && dig_q[i*DW +: DW] == DW'(BASE - 1)) k_o = KW'(i + 1);
      else stop = 1'b1;
    end
  end

  // Digits below k roll to zero, digit k takes the carry; a full carry leaves all zeros.
  always_comb begin
    dig_inc = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (KW'(i) < k_o)       dig_inc[i*DW +: DW] = '0;
      else if (KW'(i) == k_o) dig_inc[i*DW +: DW] = dig_q[i*DW +: DW] + 1'b1;
    end
  end

  always_comb begin
    dig_d = dig_q;
    if (load_i)     dig_d = seed_clean;
    else if (inc_i) dig_d = dig_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) dig_q <= '0;
    else       dig_q <= dig_d;
  end

  assign dig_o = dig_q;

endmodule

// File: rtl/halton_sng.sv
// Halton radical-inverse stochastic number generator; optional registered comparator
// output (thresh_i/sn_bit_o) is built only when HALTON_SNG_CMP_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start, outputs quiet
// INIT    | Horner accumulation of the seed, one digit per cycle
// RUN     | out valid, advances one sequence step per en
module halton_sng
  import halton_pkg::*;
#(
  parameter int unsigned BASE   = 3,
  parameter int unsigned DIGITS = 12,
  parameter int unsigned DW     = clog2_f(64'(BASE)),
  parameter int unsigned WIDTH  = clog2_f(pow_f(BASE, DIGITS))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 en_i,
  input  logic [DIGITS*DW-1:0] seed_dig_i,
`ifdef HALTON_SNG_CMP_EN
  input  logic [WIDTH-1:0]     thresh_i,
  output logic                 sn_bit_o,
`endif
  output logic [WIDTH-1:0]     out_o,
  output logic                 valid_o,
  output logic                 wrap_o,
  output logic                 busy_o,
  output logic                 seed_err_o
);

  localparam int unsigned KW = clog2_f(64'(DIGITS) + 64'd1);

  state_e               state_q, state_d;
  logic [KW-1:0]        init_q, init_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 wrap_q, wrap_d;
  logic                 seed_err_q, seed_err_d;
  logic [DIGITS*DW-1:0] dig;
  logic [KW-1:0]        k;
  logic                 seed_bad, inc;
  logic [DW-1:0]        cur_dig;
  logic [WIDTH-1:0]     adj_tbl [2**KW];

  for (genvar g = 0; g < 2**KW; g++) begin : g_adj
    if (g < DIGITS) begin : g_used
      assign adj_tbl[g] = WIDTH'(carry_adj_f(BASE, DIGITS, g));
    end else begin : g_unused
      assign adj_tbl[g] = '0;
    end
  end

  assign inc     = (state_q == ST_RUN) && en_i && !start_i;
  assign cur_dig = DW'(dig >> (DW * init_q));

  halton_digit_cnt #(
    .BASE(BASE), .DIGITS(DIGITS), .DW(DW), .KW(KW)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (start_i),
    .inc_i     (inc),
    .seed_dig_i(seed_dig_i),
    .dig_o     (dig),
    .k_o       (k),
    .seed_bad_o(seed_bad)
  );

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    out_d      = out_q;
    wrap_d     = 1'b0;
    seed_err_d = seed_err_q | (start_i & seed_bad);
    if (start_i) begin
      state_d = ST_INIT;
      init_d  = '0;
      out_d   = '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          out_d  = WIDTH'(out_q * WIDTH'(BASE)) + WIDTH'(cur_dig);
          init_d = init_q + 1'b1;
          if (init_q == KW'(DIGITS - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (en_i) begin
            if (k == KW'(DIGITS)) begin
              out_d  = '0;
              wrap_d = 1'b1;
            end else begin
              out_d = out_q + adj_tbl[k];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      init_q     <= '0;
      out_q      <= '0;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
    end
  end

`ifdef HALTON_SNG_CMP_EN
  // Compare the value out held this cycle; zero whenever RUN is entered or left.
  logic sn_bit_q, sn_bit_d;
  assign sn_bit_d = (state_q == ST_RUN) && (state_d == ST_RUN) && (out_q < thresh_i);

  always_ff @(posedge clk) begin
    if (reset) sn_bit_q <= 1'b0;
    else       sn_bit_q <= sn_bit_d;
  end

  assign sn_bit_o = sn_bit_q;
`endif

  assign out_o      = out_q;
  assign valid_o    = (state_q == ST_RUN);
  assign busy_o     = (state_q == ST_INIT);
  assign wrap_o     = wrap_q;
  assign seed_err_o = seed_err_q;

endmodule

// File: tb/tb_halton_sng.sv
// Bench for halton_sng: two instances (BASE=2/DIGITS=4 and BASE=3/DIGITS=2) checked every
// cycle against a counter-level model, plus directed literal sequences.
module tb_halton_sng;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s [2];
  logic       en_s    [2];
  logic [3:0] seed_s  [2];
  logic [3:0] out_s   [2];
  logic       valid_s [2];
  logic       wrap_s  [2];
  logic       busy_s  [2];
  logic       err_s   [2];
`ifdef HALTON_SNG_CMP_EN
  logic [3:0] thresh_s[2];
  logic       sn_s    [2];
  bit         msn     [2];
`endif

  int checks = 0;
  int errors = 0;

  int st   [2];
  int left [2];
  int cnt  [2];
  bit mwrap[2];
  bit merr [2];

  int seq2 [17] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15, 0};
  int seq3 [10] = '{0, 3, 6, 1, 4, 7, 2, 5, 8, 0};
  int sn3  [10] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0};

  always #5 clk = ~clk;

  halton_sng #(.BASE(2), .DIGITS(4)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_s[0]),
    .en_i      (en_s[0]),
    .seed_dig_i(seed_s[0]),
`ifdef HALTON_SNG_CMP_EN
    .thresh_i  (thresh_s[0]),
    .sn_bit_o  (sn_s[0]),
`endif
    .out_o     (out_s[0]),
    .valid_o   (valid_s[0]),
    .wrap_o    (wrap_s[0]),
    .busy_o    (busy_s[0]),
    .seed_err_o(err_s[0])
  );

  halton_sng #(.BASE(3), .DIGITS(2)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_s[1]),
    .en_i      (en_s[1]),
    .seed_dig_i(seed_s[1]),
`ifdef HALTON_SNG_CMP_EN
    .thresh_i  (thresh_s[1]),
    .sn_bit_o  (sn_s[1]),
`endif
    .out_o     (out_s[1]),
    .valid_o   (valid_s[1]),
    .wrap_o    (wrap_s[1]),
    .busy_o    (busy_s[1]),
    .seed_err_o(err_s[1])
  );

  function automatic int mb(input int m);
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic int md(input int m);
    return (m == 0) ? 4 : 2;
  endfunction

  function automatic int mper(input int m);
    return (m == 0) ? 16 : 9;
  endfunction

  // Radical inverse: counter digit 0 becomes the most significant output digit.
  function automatic int radinv(input int m, input int c_in);
    int v;
    int c;
    v = 0;
    c = c_in;
    for (int i = 0; i < md(m); i++) begin
      v = v * mb(m) + c % mb(m);
      c = c / mb(m);
    end
    return v;
  endfunction

  function automatic int seed_cnt(input int m, input logic [3:0] s, output bit bad);
    int dw;
    int v;
    int w;
    int dig;
    dw  = (m == 0) ? 1 : 2;
    v   = 0;
    w   = 1;
    bad = 1'b0;
    for (int i = 0; i < md(m); i++) begin
      dig = (int'(s) >> (dw * i)) & ((1 << dw) - 1);
      if (dig >= mb(m)) begin
        dig = 0;
        bad = 1'b1;
      end
      v = v + dig * w;
      w = w * mb(m);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit old_run;
      bit bad;
      int old_out;
      old_run  = (st[m] == 2);
      old_out  = radinv(m, cnt[m]);
      mwrap[m] = 1'b0;
      if (reset) begin
        st[m]   = 0;
        cnt[m]  = 0;
        merr[m] = 1'b0;
      end else if (start_s[m]) begin
        st[m]   = 1;
        left[m] = md(m);
        cnt[m]  = seed_cnt(m, seed_s[m], bad);
        if (bad) merr[m] = 1'b1;
      end else if (st[m] == 1) begin
        left[m] = left[m] - 1;
        if (left[m] == 0) st[m] = 2;
      end else if (st[m] == 2 && en_s[m]) begin
        cnt[m]   = (cnt[m] + 1) % mper(m);
        mwrap[m] = (cnt[m] == 0);
      end
`ifdef HALTON_SNG_CMP_EN
      msn[m] = (st[m] == 2) && old_run && (old_out < int'(thresh_s[m]));
`endif
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("model_valid[%0d]", m), 32'(valid_s[m]), int'(st[m] == 2));
      chk($sformatf("model_busy[%0d]", m), 32'(busy_s[m]), int'(st[m] == 1));
      chk($sformatf("model_wrap[%0d]", m), 32'(wrap_s[m]), int'(mwrap[m]));
      chk($sformatf("model_seed_err[%0d]", m), 32'(err_s[m]), int'(merr[m]));
      if (st[m] == 2) chk($sformatf("model_out[%0d]", m), 32'(out_s[m]), radinv(m, cnt[m]));
`ifdef HALTON_SNG_CMP_EN
      chk($sformatf("model_sn_bit[%0d]", m), 32'(sn_s[m]), int'(msn[m]));
`endif
    end
  end

  task automatic pulse_start(input int m, input logic [3:0] seed);
    @(negedge clk);
    seed_s[m]  = seed;
    start_s[m] = 1'b1;
    @(negedge clk);
    start_s[m] = 1'b0;
  endtask

  // Called right after pulse_start; lat counts cycles from the start cycle to valid.
  task automatic wait_valid(input int m, output int lat);
    lat = 1;
    while (valid_s[m] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int m = 0; m < 2; m++) begin
      start_s[m] = 1'b0;
      en_s[m]    = 1'b0;
      seed_s[m]  = 4'd0;
    end
`ifdef HALTON_SNG_CMP_EN
    thresh_s[0] = 4'd5;
    thresh_s[1] = 4'd4;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset_out[%0d]", m), 32'(out_s[m]), 0);
      chk($sformatf("reset_valid[%0d]", m), 32'(valid_s[m]), 0);
      chk($sformatf("reset_busy[%0d]", m), 32'(busy_s[m]), 0);
      chk($sformatf("reset_seed_err[%0d]", m), 32'(err_s[m]), 0);
    end
    reset = 1'b0;

    // Base 3, seed 0, free running over a full period
    en_s[1] = 1'b1;
    pulse_start(1, 4'b0000);
    chk("b3_busy_in_init", 32'(busy_s[1]), 1);
    wait_valid(1, lat);
    chk("b3_latency", 32'(lat), 3);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b3_seq_out[%0d]", i), 32'(out_s[1]), seq3[i]);
      chk($sformatf("b3_seq_wrap[%0d]", i), 32'(wrap_s[1]), int'(i == 9));
`ifdef HALTON_SNG_CMP_EN
      chk($sformatf("b3_seq_sn[%0d]", i), 32'(sn_s[1]), sn3[i]);
`endif
      @(negedge clk);
    end
    en_s[1] = 1'b0;

    // Base 2: bit-reversed binary counter, wrap on the 16th advance
    en_s[0] = 1'b1;
    pulse_start(0, 4'b0000);
    wait_valid(0, lat);
    chk("b2_latency", 32'(lat), 5);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("b2_seq_out[%0d]", i), 32'(out_s[0]), seq2[i]);
      chk($sformatf("b2_seq_wrap[%0d]", i), 32'(wrap_s[0]), int'(i == 16));
      @(negedge clk);
    end
    en_s[0] = 1'b0;

    // Base 2 nonzero seed through a 3-digit carry: 6, 14, then 1
    en_s[0] = 1'b1;
    pulse_start(0, 4'b0110);
    wait_valid(0, lat);
    chk("b2_seed_out0", 32'(out_s[0]), 6);
    @(negedge clk);
    chk("b2_seed_out1", 32'(out_s[0]), 14);
    @(negedge clk);
    chk("b2_seed_out2", 32'(out_s[0]), 1);
    en_s[0] = 1'b0;

    // Base 3 seed {d1=2,d0=1}, then hold with en low
    pulse_start(1, 4'b1001);
    wait_valid(1, lat);
    chk("seed21_latency", 32'(lat), 3);
    chk("seed21_out", 32'(out_s[1]), 5);
    en_s[1] = 1'b1;
    @(negedge clk);
    chk("seed21_adv_out", 32'(out_s[1]), 8);
    en_s[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_out", 32'(out_s[1]), 8);
    end

    // Start in RUN with en high: start wins and reloads
    en_s[1] = 1'b1;
    pulse_start(1, 4'b0100);
    chk("restart_busy", 32'(busy_s[1]), 1);
    wait_valid(1, lat);
    chk("restart_out", 32'(out_s[1]), 1);
    en_s[1] = 1'b0;

    // Start again mid-INIT: second seed replaces the first
    pulse_start(1, 4'b0001);
    pulse_start(1, 4'b0010);
    wait_valid(1, lat);
    chk("init_restart_latency", 32'(lat), 3);
    chk("init_restart_out", 32'(out_s[1]), 6);

    // Out-of-range seed digit is loaded as 0 and flags a sticky error
    pulse_start(1, 4'b0111);
    wait_valid(1, lat);
    chk("bad_seed_out", 32'(out_s[1]), 1);
    chk("bad_seed_err", 32'(err_s[1]), 1);
    pulse_start(1, 4'b0000);
    wait_valid(1, lat);
    chk("err_sticky", 32'(err_s[1]), 1);

    // Reset in the middle of INIT discards everything
    pulse_start(1, 4'b1001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_init_rst_out", 32'(out_s[1]), 0);
    chk("mid_init_rst_valid", 32'(valid_s[1]), 0);
    chk("mid_init_rst_busy", 32'(busy_s[1]), 0);
    chk("mid_init_rst_err", 32'(err_s[1]), 0);
    repeat (4) @(negedge clk);
    chk("idle_after_rst_valid", 32'(valid_s[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
